// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the pipelined RV32I core. Owns the PC and the
// IF/ID pipeline register. Issues word fetches to instruction memory over a
// variable-latency req/ack port. Honours the hazard-unit stall and the
// branch-resolution flush/redirect.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   stall        in   hold the PC and IF/ID
//   flush        in   taken branch/jump: redirect PC and bubble IF/ID
//   redirect_pc  in   new PC while flush=1 (bits [1:0] ignored)
//   imem_req     out  fetch request
//   imem_addr    out  fetch address (kill_addr in KILL, PC otherwise)
//   imem_ack     in   instruction data valid this cycle
//   imem_rdata   in   instruction word, sampled only with imem_ack
//   if_id_pc     out  PC of the instruction held in IF/ID
//   if_id_instr  out  instruction held in IF/ID
//   if_id_valid  out  IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_KILL
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] kill_addr_q,   kill_addr_d;
    logic [31:0] buf_pc_q,      buf_pc_d;
    logic [31:0] buf_instr_q,   buf_instr_d;
    logic        buf_valid_q,   buf_valid_d;
    logic [31:0] if_id_pc_q,    if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic [31:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & ~32'h0000_0003;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            kill_addr_q   <= RESET_PC;
            buf_pc_q      <= '0;
            buf_instr_q   <= NOP_INSTR;
            buf_valid_q   <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_addr_q   <= kill_addr_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
            buf_valid_q   <= buf_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_addr_d   = kill_addr_q;
        buf_pc_d      = buf_pc_q;
        buf_instr_d   = buf_instr_q;
        buf_valid_d   = buf_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        if (flush) begin
            // Flush beats stall and ack in every state.
            pc_d          = redirect_aligned;
            buf_valid_d   = 1'b0;
            if_id_pc_d    = pc_q;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            unique case (state_q)
                ST_REQ: begin
                    if (imem_ack) begin
                        state_d = ST_REQ;
                    end else begin
                        // The request at the old PC is still in flight; keep
                        // presenting it until its orphaned ack shows up.
                        state_d     = ST_KILL;
                        kill_addr_d = pc_q;
                    end
                end
                ST_KILL: state_d = imem_ack ? ST_REQ : ST_KILL;
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (imem_ack) begin
                        pc_d = pc_q + 32'd4;
                        if (stall) begin
                            // Decode cannot take it; park the word in the skid
                            // buffer and stop requesting.
                            buf_pc_d    = pc_q;
                            buf_instr_d = imem_rdata;
                            buf_valid_d = 1'b1;
                            state_d     = ST_HOLD;
                        end else begin
                            if_id_pc_d    = pc_q;
                            if_id_instr_d = imem_rdata;
                            if_id_valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = NOP_INSTR;
                        if_id_valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if_id_pc_d    = buf_pc_q;
                        if_id_instr_d = buf_instr_q;
                        if_id_valid_d = buf_valid_q;
                        buf_valid_d   = 1'b0;
                        state_d       = ST_REQ;
                    end
                end
                ST_KILL: begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    if (imem_ack) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign imem_req    = (state_q == ST_REQ) || (state_q == ST_KILL);
    assign imem_addr   = (state_q == ST_KILL) ? kill_addr_q : pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. The bench plays instruction memory
// (rdata = addr ^ 32'hA5A5_0000, acks only while imem_req=1) and keeps a small
// model of the expected fetch address and IF/ID contents. Words accepted into
// the pipe are pushed onto a scoreboard queue and popped when IF/ID shows them.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] KEY       = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Bench model state
    logic [63:0] sb_q[$];
    logic [31:0] exp_addr;
    logic        exp_req;
    logic        orphan;
    logic [31:0] orphan_addr;
    logic        held;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    logic [31:0] snap_pc;
    logic [31:0] snap_instr;
    logic        snap_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".imem_req"},    {31'b0, imem_req},    32'd0);
        chk({tag, ".imem_addr"},   imem_addr,            RESET_PC);
        chk({tag, ".if_id_pc"},    if_id_pc,             32'd0);
        chk({tag, ".if_id_instr"}, if_id_instr,          NOP_INSTR);
        chk({tag, ".if_id_valid"}, {31'b0, if_id_valid}, 32'd0);
    endtask

    // Called at a negedge; leaves the bench at the following negedge with the
    // IF/ID result of this cycle checked.
    task automatic do_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_pc = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n       = 1'b1;
        sb_q.delete();
        exp_addr    = RESET_PC;
        exp_req     = 1'b0;
        orphan      = 1'b0;
        orphan_addr = '0;
        held        = 1'b0;
        held_pc     = '0;
        held_instr  = '0;
        snap_pc     = '0;
        snap_instr  = NOP_INSTR;
        snap_valid  = 1'b0;
    endtask

    // One clock cycle of stimulus starting at a negedge.
    task automatic cyc(input bit ack_want, input bit st, input bit fl, input logic [31:0] rp);
        logic        a;
        logic        hold_exp;
        logic [31:0] addr;
        logic [63:0] e;

        addr = imem_addr;
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (orphan) chk("kill_addr", addr, orphan_addr);
        else        chk("imem_addr", addr, exp_addr);

        a           = ack_want && imem_req;
        imem_ack    = a;
        imem_rdata  = a ? (addr ^ KEY) : 32'h0BAD_0BAD;
        stall       = st;
        flush       = fl;
        redirect_pc = rp;
        hold_exp    = st && !fl && !orphan;

        if (fl) begin
            exp_addr = rp & ~32'h3;
            held     = 1'b0;
            if (imem_req && !a) begin
                if (!orphan) orphan_addr = addr;
                orphan = 1'b1;
            end else begin
                orphan = 1'b0;
            end
        end else if (orphan) begin
            if (a) orphan = 1'b0;
        end else if (a) begin
            exp_addr = addr + 32'd4;
            if (st) begin
                held       = 1'b1;
                held_pc    = addr;
                held_instr = addr ^ KEY;
            end else begin
                sb_q.push_back({addr, addr ^ KEY});
            end
        end else if (held && !st) begin
            sb_q.push_back({held_pc, held_instr});
            held = 1'b0;
        end
        exp_req = !held;

        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;

        if (hold_exp) begin
            chk("hold.pc",    if_id_pc,             snap_pc);
            chk("hold.instr", if_id_instr,          snap_instr);
            chk("hold.valid", {31'b0, if_id_valid}, {31'b0, snap_valid});
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("if_id.valid", {31'b0, if_id_valid}, 32'd1);
            chk("if_id.pc",    if_id_pc,             e[63:32]);
            chk("if_id.instr", if_id_instr,          e[31:0]);
        end else begin
            chk("bubble.valid", {31'b0, if_id_valid}, 32'd0);
            chk("bubble.instr", if_id_instr,          NOP_INSTR);
        end
        snap_pc    = if_id_pc;
        snap_instr = if_id_instr;
        snap_valid = if_id_valid;
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_pc = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        @(negedge clk);

        // Reset / start with zero-wait memory
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, '0);

        // Wait states: ack every third cycle
        for (int i = 0; i < 12; i++) cyc(i % 3 == 2, 1'b0, 1'b0, '0);

        // Stall beginning on the ack of 0x10
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        chk("pre_stall.addr", imem_addr, 32'h10);
        cyc(1'b1, 1'b1, 1'b0, '0);
        chk("stall.if_id_pc", if_id_pc, 32'h0C);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("release.if_id_pc",  if_id_pc,  32'h10);
        chk("release.next_addr", imem_addr, 32'h14);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);

        // Flush while the request at 0x40 is unacked, then re-flush inside KILL
        for (int i = 0; i < 40 && exp_addr != 32'h40; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, 32'h200);
        chk("kill.addr_held", imem_addr, 32'h40);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("after_kill.addr", imem_addr, 32'h200);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, 32'h280);
        cyc(1'b0, 1'b0, 1'b1, 32'h300);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("newest_redirect.addr", imem_addr, 32'h300);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, '0);

        // Flush + stall + ack in the same cycle
        cyc(1'b1, 1'b1, 1'b1, 32'h400);
        chk("fsa.next_addr", imem_addr, 32'h400);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, '0);

        // Flush while a word sits in the skid buffer: it must be dropped
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 32'h500);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);

        // Misaligned redirect and PC wrap at 2^32
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFB);
        chk("align.addr", imem_addr, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0);

        // Asynchronous reset while in HOLD
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        sb_q.delete();
        exp_addr   = RESET_PC;
        exp_req    = 1'b0;
        orphan     = 1'b0;
        held       = 1'b0;
        snap_pc    = '0;
        snap_instr = NOP_INSTR;
        snap_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
